// File: rtl/elevator_shaft_model_pkg.sv
// elevador_pkg: shared motor command encoding, shaft FSM states and fault bit indices.
// The elevator controller drives its direction output with the same CMD_* constants.
package elevador_pkg;
  localparam logic [1:0] CMD_STOP = 2'b00;
  localparam logic [1:0] CMD_UP   = 2'b01;
  localparam logic [1:0] CMD_ILL  = 2'b10;
  localparam logic [1:0] CMD_DOWN = 2'b11;
  typedef enum logic [1:0] {STOPPED, STARTING, MOVING} state_t;
  localparam int FLT_ILL   = 0;
  localparam int FLT_DOOR  = 1;
  localparam int FLT_LIMIT = 2;
endpackage

// File: rtl/elevator_shaft_model_if.sv
// elevator_shaft_model_if: controller <-> shaft bundle.
// master (controller): drives motor_cmd, door, stuck_mask, fault_clr; reads s, pavimento, pos, moving, fault.
// slave (shaft model): the mirror image.
interface elevator_shaft_model_if #(
  parameter int N_FLOORS = 5,
  parameter int TRAVEL   = 40
);
  localparam int POS_W = $clog2((N_FLOORS-1)*TRAVEL+1);
  logic [1:0]          motor_cmd;
  logic [N_FLOORS-1:0] door;
  logic [N_FLOORS-1:0] stuck_mask;
  logic                fault_clr;
  logic [N_FLOORS-1:0] s;
  logic [3:0]          pavimento;
  logic [POS_W-1:0]    pos;
  logic                moving;
  logic [2:0]          fault;
  modport master (output motor_cmd, door, stuck_mask, fault_clr,
                  input  s, pavimento, pos, moving, fault);
  modport slave  (input  motor_cmd, door, stuck_mask, fault_clr,
                  output s, pavimento, pos, moving, fault);
endinterface

// File: rtl/elevator_shaft_model_floor_sensor_decode.sv
// floor_sensor_decode: maps cabin position to per-floor zone hits and the hit floor index.
// pos in: cabin position; hit out: bit k set when |pos - k*TRAVEL| <= ZONE;
// in_zone out: any hit; floor out: 0-based index of the hit floor (0 when none).
module floor_sensor_decode #(
  parameter int N_FLOORS = 5,
  parameter int TRAVEL   = 40,
  parameter int ZONE     = 3,
  parameter int POS_W    = 8
) (
  input  logic [POS_W-1:0]    pos,
  output logic [N_FLOORS-1:0] hit,
  output logic                in_zone,
  output logic [3:0]          floor
);
  always_comb begin
    hit = '0;
    floor = '0;
    for (int k = 0; k < N_FLOORS; k++)
      if (int'(pos) >= k*TRAVEL - ZONE && int'(pos) <= k*TRAVEL + ZONE) begin
        hit[k] = 1'b1;
        floor = 4'(k);
      end
  end
  assign in_zone = |hit;
endmodule

// File: rtl/elevator_shaft_model.sv
// elevator_shaft_model: cabin/shaft plant closing the loop around the elevator controller.
// clock, reset (async, active-high); bus (slave): motor_cmd/door/stuck_mask/fault_clr in,
// s/pavimento/pos/moving/fault out. Flags illegal commands, door-open motion and limit overruns.
module elevator_shaft_model
  import elevador_pkg::*;
#(
  parameter int N_FLOORS    = 5,
  parameter int TRAVEL      = 40,
  parameter int ZONE        = 3,
  parameter int START_DLY   = 4,
  parameter int START_FLOOR = 0
) (
  input logic clock,
  input logic reset,
  elevator_shaft_model_if.slave bus
);
  localparam int POS_W = $clog2((N_FLOORS-1)*TRAVEL+1);
  localparam int CNT_W = $clog2(START_DLY+1);
  localparam logic [POS_W-1:0] POS_MAX  = POS_W'((N_FLOORS-1)*TRAVEL);
  localparam logic [POS_W-1:0] POS_INIT = POS_W'(START_FLOOR*TRAVEL);
  state_t              state_q, state_d;
  logic [1:0]          dir_q, dir_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [3:0]          pav_q, pav_d;
  logic [2:0]          fault_q, fault_d, set;
  logic [N_FLOORS-1:0] hit;
  logic                in_zone, step, door_any, at_top, at_bot, at_lim;
  logic [3:0]          floor;
  logic [1:0]          cmd;
  floor_sensor_decode #(.N_FLOORS(N_FLOORS), .TRAVEL(TRAVEL), .ZONE(ZONE), .POS_W(POS_W)) u_dec (
    .pos(pos_q), .hit(hit), .in_zone(in_zone), .floor(floor)
  );
  assign cmd      = bus.motor_cmd;
  assign door_any = |bus.door;
  assign at_top   = pos_q == POS_MAX;
  assign at_bot   = pos_q == '0;
  assign at_lim   = dir_q == CMD_UP ? at_top : at_bot;
  always_comb begin
    state_d = state_q;
    dir_d = dir_q;
    cnt_d = cnt_q;
    step = 1'b0;
    set = '0;
    case (state_q)
      STOPPED: begin
        set[FLT_ILL] = cmd == CMD_ILL;
        set[FLT_DOOR] = cmd != CMD_STOP && door_any;
        set[FLT_LIMIT] = (cmd == CMD_UP && at_top) || (cmd == CMD_DOWN && at_bot);
        if ((cmd == CMD_UP || cmd == CMD_DOWN) && !door_any && !set[FLT_LIMIT]) begin
          state_d = STARTING;
          dir_d = cmd;
          cnt_d = CNT_W'(START_DLY-1);
        end
      end
      STARTING: begin
        if (cmd == dir_q && !door_any) begin
          state_d = cnt_q == '0 ? MOVING : STARTING;
          step = cnt_q == '0;
          cnt_d = cnt_q == '0 ? cnt_q : cnt_q - CNT_W'(1);
        end else begin
          state_d = STOPPED;
          set[FLT_DOOR] = door_any;
          set[FLT_ILL] = cmd == CMD_ILL;
        end
      end
      MOVING: begin
        if (cmd == dir_q && !door_any && !at_lim) step = 1'b1;
        else begin
          state_d = STOPPED;
          set[FLT_DOOR] = door_any;
          set[FLT_ILL] = cmd == CMD_ILL;
          set[FLT_LIMIT] = cmd == dir_q && at_lim;
        end
      end
      default: state_d = STOPPED;
    endcase
  end
  assign pos_d   = step ? (dir_q == CMD_UP ? pos_q + POS_W'(1) : pos_q - POS_W'(1)) : pos_q;
  assign pav_d   = in_zone ? floor + 4'd1 : pav_q;
  // A fault raised on the clearing edge survives the clear.
  assign fault_d = (bus.fault_clr ? 3'b000 : fault_q) | set;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= STOPPED;
      dir_q <= CMD_UP;
      cnt_q <= '0;
      pos_q <= POS_INIT;
      pav_q <= 4'(START_FLOOR+1);
      fault_q <= '0;
    end else begin
      state_q <= state_d;
      dir_q <= dir_d;
      cnt_q <= cnt_d;
      pos_q <= pos_d;
      pav_q <= pav_d;
      fault_q <= fault_d;
    end
  end
  assign bus.s         = hit | bus.stuck_mask;
  assign bus.pavimento = pav_q;
  assign bus.pos       = pos_q;
  assign bus.moving    = state_q == MOVING;
  assign bus.fault     = fault_q;
endmodule

// File: tb/tb_elevator_shaft_model.sv
// tb_elevator_shaft_model: directed checks of the shaft model with hand-computed expectations.
module tb_elevator_shaft_model;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  elevator_shaft_model_if #(.N_FLOORS(5), .TRAVEL(40)) bus ();
  elevator_shaft_model #(.N_FLOORS(5), .TRAVEL(40), .ZONE(3), .START_DLY(4), .START_FLOOR(0)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  initial begin
    bus.motor_cmd = 2'b00;
    bus.door = '0;
    bus.stuck_mask = '0;
    bus.fault_clr = 1'b0;
    #12;
    check("rst_pos", bus.pos, 0);
    check("rst_s", bus.s, 5'b00001);
    check("rst_pav", bus.pavimento, 1);
    check("rst_moving", bus.moving, 0);
    check("rst_fault", bus.fault, 0);
    step(1);
    reset = 1'b0;
    step(1);
    bus.door = 5'b00001;
    bus.motor_cmd = 2'b01;
    step(2);
    check("door_pos", bus.pos, 0);
    check("door_fault", bus.fault, 3'b010);
    check("door_moving", bus.moving, 0);
    bus.door = '0;
    bus.motor_cmd = 2'b00;
    bus.fault_clr = 1'b1;
    step(1);
    bus.fault_clr = 1'b0;
    check("clr_fault", bus.fault, 0);
    bus.stuck_mask = 5'b00100;
    #1;
    check("stuck_s", bus.s, 5'b00101);
    step(1);
    check("stuck_pav", bus.pavimento, 1);
    bus.stuck_mask = '0;
    bus.motor_cmd = 2'b10;
    step(1);
    check("ill_pos", bus.pos, 0);
    check("ill_fault", bus.fault, 3'b001);
    bus.fault_clr = 1'b1;
    step(1);
    check("ill_set_wins", bus.fault, 3'b001);
    bus.motor_cmd = 2'b00;
    step(1);
    bus.fault_clr = 1'b0;
    check("ill_clr", bus.fault, 0);
    bus.motor_cmd = 2'b11;
    step(1);
    check("bot_pos", bus.pos, 0);
    check("bot_fault", bus.fault, 3'b100);
    bus.motor_cmd = 2'b00;
    bus.fault_clr = 1'b1;
    step(1);
    bus.fault_clr = 1'b0;
    bus.motor_cmd = 2'b01;
    step(1);
    check("up_e0_pos", bus.pos, 0);
    step(3);
    check("up_e3_pos", bus.pos, 0);
    check("up_e3_moving", bus.moving, 0);
    step(1);
    check("up_e4_pos", bus.pos, 1);
    check("up_e4_moving", bus.moving, 1);
    step(2);
    check("p3_s", bus.s, 5'b00001);
    step(1);
    check("p4_pos", bus.pos, 4);
    check("p4_s", bus.s, 0);
    step(32);
    check("p36_s", bus.s, 0);
    step(1);
    check("p37_s", bus.s, 5'b00010);
    check("p37_pav", bus.pavimento, 1);
    step(1);
    check("p38_pav", bus.pavimento, 2);
    step(5);
    check("p43_pos", bus.pos, 43);
    check("p43_s", bus.s, 5'b00010);
    step(1);
    check("p44_s", bus.s, 0);
    step(16);
    check("p60_pos", bus.pos, 60);
    bus.motor_cmd = 2'b11;
    step(1);
    check("rev_pos", bus.pos, 60);
    check("rev_moving", bus.moving, 0);
    step(4);
    check("rev_hold", bus.pos, 60);
    step(1);
    check("rev_59", bus.pos, 59);
    step(1);
    check("rev_58", bus.pos, 58);
    check("rev_moving2", bus.moving, 1);
    bus.motor_cmd = 2'b00;
    step(1);
    check("stop_pos", bus.pos, 58);
    check("stop_moving", bus.moving, 0);
    bus.motor_cmd = 2'b01;
    step(106);
    check("top_pos", bus.pos, 160);
    check("top_s", bus.s, 5'b10000);
    check("top_pav", bus.pavimento, 5);
    check("top_fault0", bus.fault, 0);
    step(1);
    check("lim_pos", bus.pos, 160);
    check("lim_moving", bus.moving, 0);
    check("lim_fault", bus.fault, 3'b100);
    step(2);
    check("lim_hold", bus.pos, 160);
    bus.motor_cmd = 2'b11;
    step(10);
    check("down_pos", bus.pos, 154);
    #2;
    reset = 1'b1;
    #1;
    check("arst_pos", bus.pos, 0);
    check("arst_pav", bus.pavimento, 1);
    check("arst_fault", bus.fault, 0);
    check("arst_moving", bus.moving, 0);
    bus.motor_cmd = 2'b00;
    step(1);
    reset = 1'b0;
    step(2);
    check("post_rst_pos", bus.pos, 0);
    check("post_rst_moving", bus.moving, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/elevator_shaft_model.md
# elevator_shaft_model

- Synthesizable model of the cabin and shaft that the elevator controller drives.
- Consumes the controller's motor-direction command and door outputs.
- Integrates cabin position and produces the floor sensors s[N_FLOORS-1:0] that the controller reads back.
- Closes the loop in simulation and on FPGA bring-up, and flags physically illegal commands.

## Interface
Parameters:
- N_FLOORS, 5, number of floors (floor k, 0-based, sits at pos = k*TRAVEL)
- TRAVEL, 40, position steps between adjacent floors
- ZONE, 3, sensor half-width in steps; must be < TRAVEL/2, so at most one sensor is true from position
- START_DLY, 4, cycles from accepted command to first step; must be >= 1
- START_FLOOR, 0, floor occupied after reset
- POS_W, localparam = $clog2((N_FLOORS-1)*TRAVEL+1); equals 8 at defaults

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- motor_cmd  in  2  signed direction: 2'b01 up, 2'b11 down, 2'b00 stop, 2'b10 illegal
- door  in  N_FLOORS  door-open bits from the controller, bit k = floor k
- stuck_mask  in  N_FLOORS  fault injection, ORed onto s
- fault_clr  in  1  synchronous clear of sticky faults
- s  out  N_FLOORS  floor sensors
- pavimento  out  4  last floor sensed, 1-based
- pos  out  POS_W  cabin position, 0..(N_FLOORS-1)*TRAVEL
- moving  out  1  high in state MOVING
- fault  out  3  sticky flags: [0] illegal_cmd, [1] door_interlock, [2] limit

## Operation
- States: STOPPED, STARTING, MOVING. dir register holds +1 or -1.
- STOPPED:
  - cmd up or down, no door bit set, not at the limit in that direction: go to STARTING, latch dir, load cnt = START_DLY-1.
  - cmd nonzero while any door bit is set: stay STOPPED, set fault[1].
  - cmd up at pos max, or cmd down at pos 0: stay STOPPED, set fault[2].
  - cmd 2'b10: stay STOPPED, set fault[0].
- STARTING:
  - cmd == dir and doors closed, cnt != 0: decrement cnt.
  - cmd == dir and doors closed, cnt == 0: go to MOVING and step pos by dir on the same edge.
  - Any other cmd, or any door bit set: go to STOPPED with no step. Door case also sets fault[1]; 2'b10 also sets fault[0].
- MOVING:
  - cmd == dir, doors closed, not at limit: step pos by dir every edge.
  - cmd == 0: go to STOPPED, no step.
  - cmd reversed: go to STOPPED; restart goes through STARTING again.
  - Door set: go to STOPPED and set fault[1].
  - At limit with cmd still == dir: go to STOPPED and set fault[2]. pos never leaves range.
- Sensors: s[k] = (|pos - k*TRAVEL| <= ZONE) | stuck_mask[k]. Decoded combinationally from the pos register.
- pavimento: registered. Loads k+1 on any edge where the decoded pos lies in zone k, otherwise holds. It ignores stuck_mask.
- fault_clr clears all fault bits. If a fault condition occurs on the same edge as fault_clr, the set wins.

## Timing
- Reset values:
  - pos = START_FLOOR*TRAVEL; state STOPPED; dir = +1.
  - pavimento = START_FLOOR+1; fault = 0; moving = 0.
  - s = one-hot of START_FLOOR, ORed with stuck_mask.
- Command latency: a command sampled at edge E0 in STOPPED gives the first pos change at edge E0+START_DLY, then one step per edge.
- Stop latency: cmd 0 sampled at edge E gives no step at E; moving falls after E.
- Reset mid-travel returns pos to START_FLOOR immediately (asynchronous) and cancels STARTING.

## Structure
- Package elevador_pkg holds:
  - the motor_cmd encoding constants (CMD_UP, CMD_DOWN, CMD_STOP, CMD_ILL);
  - the state enum {STOPPED, STARTING, MOVING};
  - the fault bit indices FLT_ILL, FLT_DOOR, FLT_LIMIT.
- The controller uses the same constants for its direction output.
- One sub-module: floor_sensor_decode. It is pure combinational, maps pos to a zone-hit vector plus a floor index, and is shared by the s and pavimento logic.

## Test plan
- Reset, defaults: pos=0, s=00001, pavimento=1, moving=0, fault=000.
- cmd=01 held from E0, doors closed:
  - pos=1 at E0+4; s=00000 from pos=4;
  - s=00010 for pos 37..43; pavimento=2 from the edge after pos reaches 37.
- door[0]=1 with cmd=01 at pos 0: pos stays 0, fault=010. Pulse fault_clr: fault=000.
- Drive up to pos=160: s=10000, pavimento=5. Keep cmd=01: pos stays 160, state STOPPED, fault[2]=1.
- Reversal at pos=60 (cmd 01 to 11): no step that edge, pos=60 held for 4 edges, then 59, 58, ...
- Injection and illegal command:
  - stuck_mask=00100 at pos 0: s=00101, pavimento stays 1.
  - cmd=10: pos unchanged, fault[0]=1.
